// File: rtl/multi_port_bus_access_unit_pkg.sv
// Shared types for the multi-port bus access unit: FSM states, arbitration modes
// and an index-width helper.
package BusArbiterTypes;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } BusState_t;

    localparam int unsigned PRIORITY_RR    = 0;
    localparam int unsigned PRIORITY_FIXED = 1;

    // Index width that stays at least one bit for a single-port build.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multi_port_bus_access_unit_arbiter.sv
// Combinational requester picker: round-robin from a pointer, or fixed with port 0 highest.
// The pointer register is owned by the parent.
module round_robin_arbiter
    import BusArbiterTypes::*;
#(
    parameter int unsigned NumPorts     = 2,
    parameter int unsigned PriorityMode = PRIORITY_RR,
    localparam int unsigned IdxW        = idx_width(NumPorts)
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [IdxW-1:0]     ptr_i,
    output logic [NumPorts-1:0] grant_c_o,
    output logic [IdxW-1:0]     idx_c_o
);

    logic        found;
    int unsigned start_idx;

    // Scan all ports once, starting at the pointer and wrapping.
    always_comb begin
        grant_c_o = '0;
        idx_c_o   = '0;
        found     = 1'b0;
        start_idx = (PriorityMode == PRIORITY_FIXED) ? 0 : 32'(ptr_i);
        for (int unsigned i = 0; i < NumPorts; i++) begin
            int unsigned j;
            j = start_idx + i;
            if (j >= NumPorts) begin
                j = j - NumPorts;
            end
            if (!found && req_i[IdxW'(j)]) begin
                found                  = 1'b1;
                grant_c_o[IdxW'(j)]    = 1'b1;
                idx_c_o                = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/multi_port_bus_access_unit.sv
// Arbitrates NumPorts requesters onto one APB-like master port with an optional
// per-transfer timeout that completes the transfer with an error.
module multi_port_bus_access_unit
    import BusArbiterTypes::*;
#(
    parameter int unsigned NumPorts      = 2,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned PriorityMode  = PRIORITY_RR,
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumPorts-1:0]           reqValid,
    input  logic [NumPorts*AddrWidth-1:0] reqAddr,
    input  logic [NumPorts-1:0]           reqWrite,
    input  logic [NumPorts*DataWidth-1:0] reqWdata,
    output logic [NumPorts-1:0]           reqReady,
    output logic [NumPorts-1:0]           respValid,
    output logic                          respError,
    output logic [DataWidth-1:0]          respData,
    output logic [AddrWidth-1:0]          addr,
    output logic                          select,
    output logic                          enable,
    output logic                          write,
    output logic [DataWidth-1:0]          wdata,
    input  logic [DataWidth-1:0]          rdata,
    input  logic                          ready
);

    localparam int unsigned IdxW      = idx_width(NumPorts);
    localparam int unsigned CntW      = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam bit          TimeoutEn = (TimeoutCycles != 0);
    localparam logic [CntW-1:0]     CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [IdxW-1:0]     LastIdx = IdxW'(NumPorts - 1);
    localparam logic [NumPorts-1:0] OneLsb  = NumPorts'(1);

    BusState_t              state_q;
    logic [IdxW-1:0]        ptr_q;
    logic [IdxW-1:0]        sel_q;
    logic [CntW-1:0]        cnt_q;
    logic [AddrWidth-1:0]   addr_q;
    logic                   write_q;
    logic [DataWidth-1:0]   wdata_q;
    logic                   select_q;
    logic                   enable_q;
    logic [NumPorts-1:0]    resp_valid_q;
    logic                   resp_error_q;
    logic [DataWidth-1:0]   resp_data_q;

    logic [NumPorts-1:0]    grant_c;
    logic [IdxW-1:0]        win_idx_c;
    logic [AddrWidth-1:0]   win_addr_c;
    logic                   win_write_c;
    logic [DataWidth-1:0]   win_wdata_c;
    logic [IdxW-1:0]        next_ptr_c;

    round_robin_arbiter #(
        .NumPorts     (NumPorts),
        .PriorityMode (PriorityMode)
    ) u_arbiter (
        .req_i     (reqValid),
        .ptr_i     (ptr_q),
        .grant_c_o (grant_c),
        .idx_c_o   (win_idx_c)
    );

    // Mux out the winning port's request fields.
    always_comb begin
        win_addr_c  = '0;
        win_write_c = 1'b0;
        win_wdata_c = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            if (win_idx_c == IdxW'(i)) begin
                win_addr_c  = reqAddr[i*AddrWidth +: AddrWidth];
                win_write_c = reqWrite[i];
                win_wdata_c = reqWdata[i*DataWidth +: DataWidth];
            end
        end
        next_ptr_c = (win_idx_c == LastIdx) ? '0 : win_idx_c + IdxW'(1);
    end

    assign reqReady = (rst && state_q == IDLE) ? grant_c : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            sel_q        <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            select_q     <= 1'b0;
            enable_q     <= 1'b0;
            resp_valid_q <= '0;
            resp_error_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            resp_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|reqValid) begin
                        addr_q   <= win_addr_c;
                        write_q  <= win_write_c;
                        wdata_q  <= win_wdata_c;
                        sel_q    <= win_idx_c;
                        cnt_q    <= '0;
                        select_q <= 1'b1;
                        state_q  <= SETUP;
                        if (PriorityMode == PRIORITY_RR) begin
                            ptr_q <= next_ptr_c;
                        end
                    end
                end
                SETUP: begin
                    enable_q <= 1'b1;
                    state_q  <= ACCESS;
                end
                ACCESS: begin
                    cnt_q <= cnt_q + CntW'(1);
                    // A ready in the last allowed cycle still completes without error.
                    if (ready) begin
                        resp_valid_q <= OneLsb << sel_q;
                        resp_error_q <= 1'b0;
                        resp_data_q  <= write_q ? '0 : rdata;
                        select_q     <= 1'b0;
                        enable_q     <= 1'b0;
                        state_q      <= IDLE;
                    end else if (TimeoutEn && cnt_q == CntLast) begin
                        resp_valid_q <= OneLsb << sel_q;
                        resp_error_q <= 1'b1;
                        resp_data_q  <= '0;
                        select_q     <= 1'b0;
                        enable_q     <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign respValid = resp_valid_q;
    assign respError = resp_error_q;
    assign respData  = resp_data_q;
    assign addr      = addr_q;
    assign select    = select_q;
    assign enable    = enable_q;
    assign write     = write_q;
    assign wdata     = wdata_q;

endmodule

// File: tb/tb_multi_port_bus_access_unit.sv
// Bench: instance A (3 ports, round-robin, timeout 8) and instance B (2 ports, fixed, timeout 4).
module tb_multi_port_bus_access_unit;

    localparam int unsigned NA = 3;
    localparam int unsigned NB = 2;
    localparam int unsigned TA = 8;
    localparam int unsigned TB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NA-1:0]    a_req_valid, a_req_write, a_req_ready, a_resp_valid;
    logic [NA*32-1:0] a_req_addr, a_req_wdata;
    logic             a_resp_error, a_select, a_enable, a_write, a_ready;
    logic [31:0]      a_resp_data, a_addr, a_wdata, a_rdata;
    logic [NB-1:0]    b_req_valid, b_req_write, b_req_ready, b_resp_valid;
    logic [NB*32-1:0] b_req_addr, b_req_wdata;
    logic             b_resp_error, b_select, b_enable, b_write, b_ready;
    logic [31:0]      b_resp_data, b_addr, b_wdata, b_rdata;
    int               a_waits = 0, b_waits = 0;

    multi_port_bus_access_unit #(.NumPorts(NA), .AddrWidth(32), .DataWidth(32),
        .PriorityMode(0), .TimeoutCycles(TA)) u_dut_a (
        .clk(clk), .rst(rst), .reqValid(a_req_valid), .reqAddr(a_req_addr),
        .reqWrite(a_req_write), .reqWdata(a_req_wdata), .reqReady(a_req_ready),
        .respValid(a_resp_valid), .respError(a_resp_error), .respData(a_resp_data),
        .addr(a_addr), .select(a_select), .enable(a_enable), .write(a_write),
        .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready));

    multi_port_bus_access_unit #(.NumPorts(NB), .AddrWidth(32), .DataWidth(32),
        .PriorityMode(1), .TimeoutCycles(TB)) u_dut_b (
        .clk(clk), .rst(rst), .reqValid(b_req_valid), .reqAddr(b_req_addr),
        .reqWrite(b_req_write), .reqWdata(b_req_wdata), .reqReady(b_req_ready),
        .respValid(b_resp_valid), .respError(b_resp_error), .respData(b_resp_data),
        .addr(b_addr), .select(b_select), .enable(b_enable), .write(b_write),
        .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] slave_data(input logic [31:0] a);
        return a ^ 32'hDEAD_AEEF;
    endfunction

    function automatic logic [2:0] oh(input int p);
        logic [2:0] one;
        one = 3'b001;
        return one << p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus slaves: ready after the programmed number of ACCESS cycles, noise otherwise.
    initial begin
        int acc;
        acc = 0; a_ready = 1'b0; a_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (a_enable) begin
                a_ready = (acc == a_waits);
                acc++;
            end else begin
                acc = 0;
                a_ready = 1'($urandom_range(0, 1));
            end
            a_rdata = a_ready ? slave_data(a_addr) : $urandom;
        end
    end

    initial begin
        int acc;
        acc = 0; b_ready = 1'b0; b_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (b_enable) begin
                b_ready = (acc == b_waits);
                acc++;
            end else begin
                acc = 0;
                b_ready = 1'($urandom_range(0, 1));
            end
            b_rdata = b_ready ? slave_data(b_addr) : $urandom;
        end
    end

    task automatic set_req(input int inst, input int p, input logic v, input logic [31:0] ad,
                           input logic w, input logic [31:0] wd);
        if (inst == 0) begin
            a_req_valid[p] = v; a_req_write[p] = w;
            a_req_addr[p*32 +: 32] = ad; a_req_wdata[p*32 +: 32] = wd;
        end else begin
            b_req_valid[p] = v; b_req_write[p] = w;
            b_req_addr[p*32 +: 32] = ad; b_req_wdata[p*32 +: 32] = wd;
        end
    endtask

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          waits;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_data;
    } vec_t;

    // One transfer from an idle unit; lat is the respValid cycle relative to the request.
    task automatic run_txn(input vec_t v, output int lat, output logic [2:0] rv,
                           output logic err, output logic [31:0] data);
        lat = -1; rv = '0; err = 1'b0; data = '0;
        @(posedge clk); #1;
        if (v.inst == 0) a_waits = v.waits; else b_waits = v.waits;
        set_req(v.inst, v.port, 1'b1, v.addr, v.wr, v.wdata);
        for (int c = 0; c < 64; c++) begin
            logic [2:0] rdy, rsp;
            @(negedge clk);
            rdy = (v.inst == 0) ? a_req_ready : {1'b0, b_req_ready};
            rsp = (v.inst == 0) ? a_resp_valid : {1'b0, b_resp_valid};
            if (c == 0) check("vec_grant", 64'(rdy), 64'(oh(v.port)));
            if (rsp != 0) begin
                lat = c; rv = rsp;
                err  = (v.inst == 0) ? a_resp_error : b_resp_error;
                data = (v.inst == 0) ? a_resp_data : b_resp_data;
                break;
            end
            @(posedge clk); #1;
            if (c == 0) set_req(v.inst, v.port, 1'b0, v.addr, v.wr, v.wdata);
        end
    endtask

    task automatic grant_seq(input int inst, input int exp_port_step, output int n_starve);
        int gport[$], gcyc[$];
        n_starve = 0;
        @(posedge clk); #1;
        for (int p = 0; p < ((inst == 0) ? 3 : 2); p++)
            set_req(inst, p, 1'b1, 32'h100 * (p + 1), 1'b0, 32'h0);
        for (int c = 0; c < 40 && gport.size() < 6; c++) begin
            logic [2:0] rdy;
            @(negedge clk);
            rdy = (inst == 0) ? a_req_ready : {1'b0, b_req_ready};
            if (inst == 1 && rdy[1]) n_starve++;
            for (int p = 0; p < 3; p++)
                if (rdy[p]) begin gport.push_back(p); gcyc.push_back(c); end
            @(posedge clk); #1;
        end
        if (inst == 0) a_req_valid = '0; else b_req_valid = '0;
        check(inst == 0 ? "rr_grant_count" : "fix_grant_count", 64'(gport.size()), 64'd6);
        for (int i = 0; i < gport.size(); i++) begin
            check(inst == 0 ? "rr_grant_port" : "fix_grant_port", 64'(gport[i]),
                  64'((i * exp_port_step) % 3));
            check(inst == 0 ? "rr_grant_cycle" : "fix_grant_cycle", 64'(gcyc[i]), 64'(3 * i));
        end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   lat, starve;
        logic [2:0]  rv;
        logic        err;
        logic [31:0] data;

        vecs[0] = '{0, 0, 32'h0000_1000, 1'b0, 32'h0,      0,  3, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{0, 2, 32'h2000_0040, 1'b1, 32'h55AA,   5,  8, 1'b0, 32'h0};
        vecs[2] = '{0, 1, 32'h0000_0ABC, 1'b0, 32'h0,      2,  5, 1'b0, 32'hDEAD_A453};
        vecs[3] = '{1, 0, 32'h0000_3000, 1'b0, 32'h0,    100,  6, 1'b1, 32'h0};
        vecs[4] = '{1, 1, 32'h0000_1000, 1'b0, 32'h0,      3,  6, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1, 1, 32'h0000_0044, 1'b1, 32'h1234,   0,  3, 1'b0, 32'h0};
        vecs[6] = '{0, 0, 32'h0000_0900, 1'b1, 32'hCAFE,  20, 10, 1'b1, 32'h0};

        // Reset state, with requests asserted to show reqReady stays low.
        rst = 1'b0;
        a_req_valid = '1; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = '1; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(a_req_ready), 64'd0);
        check("rst_select", 64'(a_select), 64'd0);
        check("rst_enable", 64'(a_enable), 64'd0);
        check("rst_resp_valid", 64'(a_resp_valid), 64'd0);
        check("rst_resp_error", 64'(a_resp_error), 64'd0);
        check("rst_resp_data", 64'(a_resp_data), 64'd0);
        check("rst_addr", 64'(a_addr), 64'd0);
        check("rst_write_wdata", 64'({a_write, a_wdata}), 64'd0);
        check("rst_b_outputs", 64'({b_req_ready, b_select, b_enable, b_resp_valid}), 64'd0);
        a_req_valid = '0; b_req_valid = '0;
        @(negedge clk); rst = 1'b1;

        a_waits = 0; b_waits = 0;
        grant_seq(0, 1, starve);
        grant_seq(1, 0, starve);
        check("fix_port1_starved", 64'(starve), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], lat, rv, err, data);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_resp_port", i), 64'(rv), 64'(oh(vecs[i].port)));
            check($sformatf("vec%0d_resp_error", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_resp_data", i), 64'(data), 64'(vecs[i].exp_data));
            @(negedge clk);
            check($sformatf("vec%0d_select_after", i),
                  64'(vecs[i].inst == 0 ? a_select : b_select), 64'd0);
        end

        // Reset while A sits in ACCESS, then the pointer must be back at port 0.
        begin
            int r_cyc[$], r_port[$];
            logic [31:0] r_data[$];
            @(posedge clk); #1;
            a_waits = 50;
            set_req(0, 0, 1'b1, 32'h500, 1'b0, 32'h0);
            @(posedge clk); #1;
            set_req(0, 0, 1'b0, 32'h500, 1'b0, 32'h0);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (a_enable) break;
            end
            check("mid_enable_seen", 64'(a_enable), 64'd1);
            set_req(0, 2, 1'b1, 32'h800, 1'b0, 32'h0);
            rst = 1'b0;
            #1;
            check("mid_rst_select", 64'(a_select), 64'd0);
            check("mid_rst_enable", 64'(a_enable), 64'd0);
            check("mid_rst_resp_valid", 64'(a_resp_valid), 64'd0);
            check("mid_rst_req_ready", 64'(a_req_ready), 64'd0);
            repeat (2) @(negedge clk);
            a_req_valid = '0;
            rst = 1'b1;
            @(posedge clk); #1;
            a_waits = 0;
            set_req(0, 0, 1'b1, 32'h600, 1'b0, 32'h0);
            set_req(0, 1, 1'b1, 32'h700, 1'b0, 32'h0);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (c == 0) check("post_rst_grant", 64'(a_req_ready), 64'd1);
                if (a_resp_valid != 0) begin
                    r_cyc.push_back(c);
                    r_port.push_back(a_resp_valid == 3'b010 ? 1 : (a_resp_valid == 3'b001 ? 0 : 9));
                    r_data.push_back(a_resp_data);
                end
                if (a_req_ready[1]) begin @(posedge clk); #1; a_req_valid[1] = 1'b0; end
                else begin @(posedge clk); #1; end
                if (c == 0) a_req_valid[0] = 1'b0;
            end
            check("post_rst_resp_count", 64'(r_cyc.size()), 64'd2);
            if (r_cyc.size() == 2) begin
                check("post_rst_resp0_cycle", 64'(r_cyc[0]), 64'd3);
                check("post_rst_resp0_port", 64'(r_port[0]), 64'd0);
                check("post_rst_resp0_data", 64'(r_data[0]), 64'(slave_data(32'h600)));
                check("post_rst_resp1_cycle", 64'(r_cyc[1]), 64'd6);
                check("post_rst_resp1_port", 64'(r_port[1]), 64'd1);
                check("post_rst_resp1_data", 64'(r_data[1]), 64'(slave_data(32'h700)));
            end
        end

        // Randomized traffic on A against a transaction-timeline model.
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        begin
            bit          pend[3];
            logic [31:0] p_addr[3], p_wd[3];
            logic        p_wr[3];
            int          m_ptr, m_port, m_g, m_r, m_waits;
            bit          m_busy, m_err;
            logic [31:0] m_addr, m_wd;
            logic        m_wr;
            m_ptr = 0; m_busy = 0; m_port = 0; m_g = 0; m_r = 0; m_err = 0;
            m_addr = '0; m_wd = '0; m_wr = 1'b0;
            for (int p = 0; p < 3; p++) begin pend[p] = 0; p_addr[p] = '0; p_wd[p] = '0; p_wr[p] = 0; end
            for (int k = 0; k < 600; k++) begin
                logic [2:0]  e_grant, e_resp;
                logic        e_sel, e_en, e_err, e_wr;
                logic [31:0] e_data, e_addr, e_wd;
                bit          idle;
                @(posedge clk); #1;
                e_resp = (m_busy && k == m_r) ? oh(m_port) : 3'b000;
                e_err  = m_err;
                e_data = (m_err || m_wr) ? 32'h0 : slave_data(m_addr);
                e_sel  = m_busy && k > m_g && k < m_r;
                e_en   = m_busy && k > m_g + 1 && k < m_r;
                e_addr = m_addr; e_wr = m_wr; e_wd = m_wd;
                idle   = !m_busy || k == m_r;
                for (int p = 0; p < 3; p++) begin
                    if (!pend[p] && $urandom_range(0, 2) == 0) begin
                        pend[p] = 1; p_addr[p] = $urandom; p_wr[p] = 1'($urandom_range(0, 1));
                        p_wd[p] = $urandom;
                    end
                    set_req(0, p, pend[p], p_addr[p], p_wr[p], p_wd[p]);
                end
                e_grant = '0;
                if (idle) begin
                    m_busy = 0;
                    for (int i = 0; i < 3; i++) begin
                        int j;
                        j = (m_ptr + i) % 3;
                        if (!m_busy && pend[j]) begin
                            m_busy = 1; m_port = j; e_grant = oh(j);
                            m_addr = p_addr[j]; m_wr = p_wr[j]; m_wd = p_wd[j];
                            m_waits = $urandom_range(0, 10);
                            a_waits = m_waits;
                            m_g = k;
                            m_r = k + 3 + ((m_waits < TA) ? m_waits : TA - 1);
                            m_err = (m_waits >= TA);
                            m_ptr = (j + 1) % 3;
                            pend[j] = 0;
                        end
                    end
                end
                @(negedge clk);
                check("rnd_req_ready", 64'(a_req_ready), 64'(e_grant));
                check("rnd_resp_valid", 64'(a_resp_valid), 64'(e_resp));
                check("rnd_select", 64'(a_select), 64'(e_sel));
                check("rnd_enable", 64'(a_enable), 64'(e_en));
                if (e_resp != 0) begin
                    check("rnd_resp_error", 64'(a_resp_error), 64'(e_err));
                    check("rnd_resp_data", 64'(a_resp_data), 64'(e_data));
                end
                if (e_sel) begin
                    check("rnd_addr", 64'(a_addr), 64'(e_addr));
                    check("rnd_write", 64'(a_write), 64'(e_wr));
                    check("rnd_wdata", 64'(a_wdata), 64'(e_wd));
                end
            end
            a_req_valid = '0;
            repeat (16) @(posedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
